i2c_bus_monitor: RTL

Passive, parametrised I2C bus monitor for one bus. It oversamples raw SCL/SDA on a system clock, glitch-filters both lines, and decodes START, repeated START, data bytes with ACK/NACK, STOP and protocol errors. Decoded events are queued in an internal FIFO and drained over a valid/ready stream. It sits beside the bus as a synthesizable checker and protocol logger for the verification environment and for on-chip debug.

---
 rtl/i2c_mon_pkg.sv | 38 +++
 rtl/i2c_mon_fifo.sv | 48 ++++
 rtl/i2c_bus_monitor.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_mon_pkg.sv
// Shared types for the I2C bus monitor: event codes, decoder states and the queued event record.
package i2c_mon_pkg;

    typedef enum logic [2:0] {
        EVT_START   = 3'd0,
        EVT_RSTART  = 3'd1,
        EVT_BYTE    = 3'd2,
        EVT_STOP    = 3'd3,
        EVT_ERR     = 3'd4,
        EVT_TIMEOUT = 3'd5
    } evt_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BITS = 2'd1,
        ACK  = 2'd2
    } fsm_state_e;

    typedef struct packed {
        evt_type_e  etype;
        logic [7:0] data;
        logic       ack;
        logic       addr;
    } evt_t;

    localparam int DROP_W = 8;

    function automatic evt_t mk_evt(input evt_type_e t, input logic [7:0] d,
                                    input logic a, input logic ad);
        evt_t e;
        e.etype = t;
        e.data  = d;
        e.ack   = a;
        e.addr  = ad;
        return e;
    endfunction

endpackage

// File: rtl/i2c_mon_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module i2c_mon_fifo
    import i2c_mon_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  evt_t push_evt,
    input  logic pop,
    output evt_t head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    evt_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_evt;
        end
    end

    // NOTE: non-blocking assignments on all state so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: filters SCL/SDA, decodes bus conditions and bytes, queues events.
// Define I2C_MON_TIMEOUT_EN to build the stuck-SCL timeout counter (TIMEOUT_CYC).
module i2c_bus_monitor
    import i2c_mon_pkg::*;
#(
    parameter int FILT_LEN    = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [2:0]        evt_type,
    output logic [7:0]        evt_data,
    output logic              evt_ack,
    output logic              evt_addr,
    output logic              busy,
    output logic              ovf,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam logic [3:0] FCNT_MAX = 4'(FILT_LEN - 1);

    // Index 1 carries SCL, index 0 carries SDA throughout the input path.
    logic [1:0] s1, s2, filt, filt_d;
    logic [3:0] fcnt [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 2'b11;
            s2      <= 2'b11;
            filt    <= 2'b11;
            filt_d  <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            s1     <= {scl_i, sda_i};
            s2     <= s1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FCNT_MAX) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_d, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_f     = filt[1];
    assign sda_f     = filt[0];
    assign scl_d     = filt_d[1];
    assign sda_d     = filt_d[0];
    assign scl_rise  = scl_f && !scl_d;
    assign scl_fall  = !scl_f && scl_d;
    assign start_det = scl_f && scl_d && sda_d && !sda_f;
    assign stop_det  = scl_f && scl_d && !sda_d && sda_f;

    fsm_state_e state, state_nx;
    logic [2:0] bit_cnt, cnt_nx;
    logic [7:0] shreg, shreg_nx;
    logic       addr_flag, addr_nx;
    logic       pend, pend_nx;
    logic       pend_bit, pbit_nx;
    logic       ev0_v, ev1_v;
    evt_t       ev0, ev1;
    logic       timeout_hit;

    assign busy = (state != IDLE);

`ifdef I2C_MON_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = busy && !scl_f && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !busy || scl_rise || timeout_hit) begin
            to_cnt <= '0;
        end else if (!scl_f) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            addr_flag <= 1'b0;
            pend      <= 1'b0;
            pend_bit  <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= cnt_nx;
            shreg     <= shreg_nx;
            addr_flag <= addr_nx;
            pend      <= pend_nx;
            pend_bit  <= pbit_nx;
        end
    end

    // A bit is sampled on the SCL rise but only committed on the fall, so the rise
    // that precedes a START/STOP is never counted as data.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nx = state;
        cnt_nx   = bit_cnt;
        shreg_nx = shreg;
        addr_nx  = addr_flag;
        pend_nx  = pend;
        pbit_nx  = pend_bit;
        ev0_v    = 1'b0;
        ev1_v    = 1'b0;
        ev0      = '0;
        ev1      = '0;
        if (timeout_hit) begin
            state_nx = IDLE;
            pend_nx  = 1'b0;
            ev0_v    = 1'b1;
            ev0      = mk_evt(EVT_TIMEOUT, 8'h00, 1'b0, 1'b0);
        end else begin
            case (state)
                IDLE: begin
                    if (start_det) begin
                        state_nx = BITS;
                        cnt_nx   = '0;
                        addr_nx  = 1'b1;
                        pend_nx  = 1'b0;
                        ev0_v    = 1'b1;
                        ev0      = mk_evt(EVT_START, 8'h00, 1'b0, 1'b0);
                    end
                end
                default: begin
                    if (start_det || stop_det) begin
                        pend_nx = 1'b0;
                        cnt_nx  = '0;
                        ev0_v   = 1'b1;
                        if (state == BITS && bit_cnt == 3'd0) begin
                            ev0 = mk_evt(start_det ? EVT_RSTART : EVT_STOP, 8'h00, 1'b0, 1'b0);
                        end else begin
                            ev0   = mk_evt(EVT_ERR, (state == ACK) ? 8'd8 : {5'd0, bit_cnt},
                                           1'b0, 1'b0);
                            ev1_v = 1'b1;
                            ev1   = mk_evt(start_det ? EVT_RSTART : EVT_STOP, 8'h00, 1'b0, 1'b0);
                        end
                        if (start_det) begin
                            state_nx = BITS;
                            addr_nx  = 1'b1;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else if (scl_rise) begin
                        pend_nx = 1'b1;
                        pbit_nx = sda_f;
                    end else if (scl_fall && pend) begin
                        pend_nx = 1'b0;
                        if (state == BITS) begin
                            shreg_nx = {shreg[6:0], pend_bit};
                            if (bit_cnt == 3'd7) begin
                                state_nx = ACK;
                                cnt_nx   = '0;
                            end else begin
                                cnt_nx = bit_cnt + 3'd1;
                            end
                        end else begin
                            ev0_v    = 1'b1;
                            ev0      = mk_evt(EVT_BYTE, shreg, !pend_bit, addr_flag);
                            addr_nx  = 1'b0;
                            state_nx = BITS;
                            cnt_nx   = '0;
                        end
                    end
                end
            endcase
        end
    end

    // Push stage; an ERR's follow-up waits one cycle in the holding register.
    logic push_q, hold_v;
    evt_t push_evt, hold_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            push_q   <= 1'b0;
            push_evt <= '0;
            hold_v   <= 1'b0;
            hold_evt <= '0;
        end else if (hold_v) begin
            push_q   <= 1'b1;
            push_evt <= hold_evt;
            hold_v   <= ev0_v;
            hold_evt <= ev0;
        end else begin
            push_q   <= ev0_v;
            push_evt <= ev0;
            hold_v   <= ev1_v;
            hold_evt <= ev1;
        end
    end

    evt_t fifo_head;
    logic fifo_full, fifo_empty, pop, drop;

    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;
    assign drop      = push_q && fifo_full && !pop;

    i2c_mon_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_q),
        .push_evt (push_evt),
        .pop      (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign evt_type = evt_valid ? fifo_head.etype : 3'd0;
    assign evt_data = evt_valid ? fifo_head.data  : 8'h00;
    assign evt_ack  = evt_valid && fifo_head.ack;
    assign evt_addr = evt_valid && fifo_head.addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

endmodule
